pobieranie_rozkazu: RTL and testbench

//  Instruction fetch stage for the PLC core; sits directly upstream of the opcode decoder.

---
 rtl/pobieranie_rozkazu.sv | 105 ++++++++++
 tb/tb_pobieranie_rozkazu.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pobieranie_rozkazu.sv
// Instruction fetch stage: owns the PC, reads opcode/operand byte pairs from a synchronous ROM
// and hands complete instructions to the decoder over a valid/ready handshake.
module pobieranie_rozkazu #(
    parameter int ADDR_W   = 8,
    parameter int RST_ADDR = 0,
    parameter int NOP_OPC  = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rst_prog,
    input  logic              wstrzymaj,
    output logic [ADDR_W-1:0] adres_rom,
    input  logic [7:0]        dane_z_rom,
    output logic [7:0]        dane_rom,
    output logic [7:0]        argument,
    output logic              rozkaz_valid,
    input  logic              gotowy,
    input  logic              jmp_en,
    output logic [ADDR_W-1:0] pc,
    output logic [15:0]       licznik
);

    typedef enum logic [1:0] {
        S_OPC  = 2'd0,
        S_ARG  = 2'd1,
        S_LAT  = 2'd2,
        S_EXEC = 2'd3
    } stan_t;

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RST_ADDR);
    localparam logic [7:0]        NOP    = 8'(NOP_OPC);

    stan_t             stan_q;
    logic [ADDR_W-1:0] pc_q;
    logic [7:0]        opcode_q;
    logic [7:0]        argument_q;
    logic              valid_q;
    logic [15:0]       licznik_q;

    logic [ADDR_W-1:0] pc_inc1_d;
    logic [ADDR_W-1:0] pc_inc2_d;
    logic [ADDR_W-1:0] skok_d;

    // Natural wrap of the ADDR_W-bit sums gives the modulo-2**ADDR_W PC arithmetic.
    assign pc_inc1_d = pc_q + ADDR_W'(1);
    assign pc_inc2_d = pc_q + ADDR_W'(2);
    assign skok_d    = ADDR_W'(argument_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stan_q     <= S_OPC;
            pc_q       <= PC_RST;
            opcode_q   <= NOP;
            argument_q <= 8'd0;
            valid_q    <= 1'b0;
            licznik_q  <= 16'd0;
        end else if (rst_prog) begin
            // Program restart drops any held instruction without counting it.
            stan_q  <= S_OPC;
            pc_q    <= PC_RST;
            valid_q <= 1'b0;
        end else begin
            case (stan_q)
                S_OPC: begin
                    if (!wstrzymaj) begin
                        stan_q <= S_ARG;
                    end
                end
                S_ARG: begin
                    opcode_q <= dane_z_rom;
                    stan_q   <= S_LAT;
                end
                S_LAT: begin
                    argument_q <= dane_z_rom;
                    pc_q       <= pc_inc2_d;
                    valid_q    <= 1'b1;
                    stan_q     <= S_EXEC;
                end
                S_EXEC: begin
                    if (gotowy) begin
                        licznik_q <= licznik_q + 16'd1;
                        if (jmp_en) begin
                            pc_q <= skok_d;
                        end
                        valid_q <= 1'b0;
                        stan_q  <= S_OPC;
                    end
                end
                default: begin
                    stan_q  <= S_OPC;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    // The operand address is held through S_LAT, where pc_q still holds the opcode address.
    assign adres_rom    = (stan_q == S_ARG || stan_q == S_LAT) ? pc_inc1_d : pc_q;
    assign dane_rom     = (stan_q == S_EXEC) ? opcode_q : NOP;
    assign argument     = argument_q;
    assign rozkaz_valid = valid_q;
    assign pc           = pc_q;
    assign licznik      = licznik_q;

endmodule

// File: tb/tb_pobieranie_rozkazu.sv
// Self-checking bench for pobieranie_rozkazu: a ROM model plus an instruction-level reference
// model (pc, instruction count) checked at every phase of each fetched instruction.
module tb_pobieranie_rozkazu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_prog = 1'b0;
    logic        wstrzymaj = 1'b0;
    logic        gotowy = 1'b0;
    logic        jmp_en = 1'b0;
    logic [7:0]  adres_rom;
    logic [7:0]  dane_z_rom;
    logic [7:0]  dane_rom;
    logic [7:0]  argument;
    logic        rozkaz_valid;
    logic [7:0]  pc;
    logic [15:0] licznik;

    logic [7:0]  rom [256];
    int          n_cmp = 0;
    int          n_err = 0;
    int          m_pc  = 0;
    int          m_cnt = 0;

    pobieranie_rozkazu #(.ADDR_W(8), .RST_ADDR(0), .NOP_OPC(31)) dut (
        .clk(clk), .rst_n(rst_n), .rst_prog(rst_prog), .wstrzymaj(wstrzymaj),
        .adres_rom(adres_rom), .dane_z_rom(dane_z_rom), .dane_rom(dane_rom),
        .argument(argument), .rozkaz_valid(rozkaz_valid), .gotowy(gotowy),
        .jmp_en(jmp_en), .pc(pc), .licznik(licznik)
    );

    always #5 clk = ~clk;

    // Synchronous program ROM: data one clock after the address.
    always @(posedge clk) dane_z_rom <= rom[adres_rom];

    // Fetches one instruction starting at a negedge with the DUT idle in its fetch-start state.
    // abort: 0 = normal accept, 1 = rst_prog together with gotowy while held,
    //        2 = asynchronous reset pulse while the operand address is out.
    task automatic run_instr(input bit jmp, input int stall, input int hold, input int abort);
        logic [7:0]  op;
        logic [7:0]  arg;
        logic [40:0] got_s;
        logic [40:0] exp_s;
        logic [48:0] got_x;
        logic [48:0] exp_x;
        int          next_pc;
        op      = rom[m_pc];
        arg     = rom[(m_pc + 1) % 256];
        next_pc = (m_pc + 2) % 256;

        wstrzymaj = 1'b0; gotowy = 1'($urandom); jmp_en = 1'($urandom);
        got_s = {adres_rom, dane_rom, rozkaz_valid, pc, licznik};
        exp_s = {8'(m_pc), 8'd31, 1'b0, 8'(m_pc), 16'(m_cnt)};
        n_cmp++;
        if (got_s !== exp_s) begin
            n_err++; $display("FAIL s_opc got %h required %h", got_s, exp_s);
        end
        @(negedge clk);

        wstrzymaj = (hold > 0) ? 1'b1 : 1'($urandom);
        gotowy = 1'($urandom); jmp_en = 1'($urandom);
        got_s = {adres_rom, dane_rom, rozkaz_valid, pc, licznik};
        exp_s = {8'((m_pc + 1) % 256), 8'd31, 1'b0, 8'(m_pc), 16'(m_cnt)};
        n_cmp++;
        if (got_s !== exp_s) begin
            n_err++; $display("FAIL s_arg got %h required %h", got_s, exp_s);
        end
        if (abort == 2) begin
            wstrzymaj = 1'b1;
            #2 rst_n = 1'b0;
            #1;
            got_x = {adres_rom, dane_rom, argument, rozkaz_valid, pc, licznik};
            exp_x = {8'd0, 8'd31, 8'd0, 1'b0, 8'd0, 16'd0};
            n_cmp++;
            if (got_x !== exp_x) begin
                n_err++; $display("FAIL async_rst got %h required %h", got_x, exp_x);
            end
            #1 rst_n = 1'b1;
            m_pc = 0; m_cnt = 0;
            $display("instr pc=%02h async reset during operand fetch", 8'(m_pc));
            @(negedge clk);
            return;
        end
        @(negedge clk);

        wstrzymaj = (hold > 0) ? 1'b1 : 1'($urandom);
        gotowy = 1'($urandom); jmp_en = 1'($urandom);
        n_cmp++;
        got_s = {adres_rom, dane_rom, rozkaz_valid, pc, licznik};
        if (got_s !== exp_s) begin
            n_err++; $display("FAIL s_lat got %h required %h", got_s, exp_s);
        end
        @(negedge clk);

        for (int i = 0; i <= stall; i++) begin
            got_x = {adres_rom, dane_rom, argument, rozkaz_valid, pc, licznik};
            exp_x = {8'(next_pc), op, arg, 1'b1, 8'(next_pc), 16'(m_cnt)};
            n_cmp++;
            if (got_x !== exp_x) begin
                n_err++; $display("FAIL s_exec[%0d] got %h required %h", i, got_x, exp_x);
            end
            if (i < stall) begin
                gotowy = 1'b0; jmp_en = 1'($urandom);
                @(negedge clk);
            end
        end

        if (abort == 1) begin
            gotowy = 1'b1; jmp_en = 1'($urandom); rst_prog = 1'b1;
            @(negedge clk);
            rst_prog = 1'b0; gotowy = 1'b0; jmp_en = 1'b0;
            m_pc = 0;
            got_s = {adres_rom, dane_rom, rozkaz_valid, pc, licznik};
            exp_s = {8'd0, 8'd31, 1'b0, 8'd0, 16'(m_cnt)};
            n_cmp++;
            if (got_s !== exp_s) begin
                n_err++; $display("FAIL rst_prog got %h required %h", got_s, exp_s);
            end
            $display("instr op=%02h arg=%02h discarded by rst_prog", op, arg);
            return;
        end

        gotowy = 1'b1; jmp_en = jmp;
        @(negedge clk);
        gotowy = 1'b0; jmp_en = 1'b0;
        m_cnt = (m_cnt + 1) % 65536;
        m_pc  = jmp ? int'(arg) : next_pc;
        $display("instr op=%02h arg=%02h jmp=%0d stall=%0d hold=%0d -> pc=%02h cnt=%0d",
                 op, arg, jmp, stall, hold, 8'(m_pc), m_cnt);

        for (int h = 0; h < hold; h++) begin
            got_s = {adres_rom, dane_rom, rozkaz_valid, pc, licznik};
            exp_s = {8'(m_pc), 8'd31, 1'b0, 8'(m_pc), 16'(m_cnt)};
            n_cmp++;
            if (got_s !== exp_s) begin
                n_err++; $display("FAIL s_hold[%0d] got %h required %h", h, got_s, exp_s);
            end
            gotowy = 1'($urandom);
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        logic [48:0] got_x;
        logic [48:0] exp_x;
        #1;
        got_x = {adres_rom, dane_rom, argument, rozkaz_valid, pc, licznik};
        exp_x = {8'd0, 8'd31, 8'd0, 1'b0, 8'd0, 16'd0};
        n_cmp++;
        if (got_x !== exp_x) begin
            n_err++; $display("FAIL reset got %h required %h", got_x, exp_x);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        run_instr(1'b0, 0, 0, 0);
    endtask

    task automatic test_stall_jump;
        run_instr(1'b1, 5, 0, 0);
    endtask

    task automatic test_wrap;
        run_instr(1'b1, 0, 0, 0);
        run_instr(1'b0, 0, 0, 0);
        rom[1] = 8'hFF;
        run_instr(1'b1, 0, 0, 0);
        run_instr(1'b0, 0, 0, 0);
    endtask

    task automatic test_halt;
        run_instr(1'b0, 1, 3, 0);
        run_instr(1'b0, 0, 0, 0);
    endtask

    task automatic test_rst_prog;
        run_instr(1'b0, 0, 0, 1);
        run_instr(1'b0, 0, 0, 0);
    endtask

    task automatic test_async_reset;
        run_instr(1'b0, 0, 0, 2);
        run_instr(1'b0, 2, 0, 0);
    endtask

    task automatic test_random;
        for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
        for (int n = 0; n < 40; n++) begin
            run_instr(1'($urandom), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 0);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 8'($urandom);
        rom[8'h00] = 8'h0D; rom[8'h01] = 8'h05;
        rom[8'h02] = 8'h1B; rom[8'h03] = 8'h40;
        rom[8'h41] = 8'hFE;
        test_reset();
        test_basic();
        test_stall_jump();
        test_wrap();
        test_halt();
        test_rst_prog();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
